// File: rtl/ccff_chain_loader_if.sv
// Bitstream word stream into the configuration chain loader.
// Source drives data/valid; loader returns ready.
interface ccff_chain_loader_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready
  );
endinterface

// File: rtl/ccff_chain_loader.sv
// Configuration chain sequencer: LOAD shifts the bitstream into
// ccff_head, TEST walks a single one from head to tail.
module ccff_chain_loader #(
  parameter int BITSTREAM_SIZE = 2655,
  parameter int WORD_W         = 32,
  parameter int CNT_W          = 12
) (
  input  logic             prog_clk,
  input  logic             prog_reset,
  input  logic             start,
  input  logic             mode,
  ccff_chain_loader_if.slave s,
  output logic             ccff_head,
  output logic             ccff_shift_en,
  input  logic             ccff_tail,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] bit_count
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] SIZE =
    CNT_W'(BITSTREAM_SIZE);
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(WORD_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SHIFT,
    T_INJ,
    T_RUN,
    FINISH
  } state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] buf_q, buf_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic              head_q, head_d;
  logic              sen_q, sen_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              chk_vld_q, chk_vld_d;
  logic [CNT_W-1:0]  chk_cnt_q, chk_cnt_d;

  assign cnt_inc = (cnt_q == SIZE) ? cnt_q
                 : cnt_q + CNT_W'(1);

  // Tail reflects a shift one cycle after the shift_en cycle,
  // so the count of that shift is carried along with it.
  assign chk_vld_d = sen_q;
  assign chk_cnt_d = cnt_q;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    head_d  = 1'b0;
    sen_d   = 1'b0;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = mode ? T_INJ : FETCH;
        end
      end
      FETCH: begin
        if (s.s_valid) begin
          buf_d   = s.s_data;
          idx_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        head_d = buf_q[WORD_W-1];
        sen_d  = 1'b1;
        buf_d  = {buf_q[WORD_W-2:0], 1'b0};
        cnt_d  = cnt_inc;
        idx_d  = idx_q + IDX_W'(1);
        if (cnt_inc == SIZE) begin
          state_d = FINISH;
        end else if (idx_q == LAST) begin
          state_d = FETCH;
        end
      end
      T_INJ: begin
        head_d  = 1'b1;
        sen_d   = 1'b1;
        cnt_d   = CNT_W'(1);
        state_d = T_RUN;
      end
      T_RUN: begin
        if (chk_vld_q && (chk_cnt_q == SIZE)) begin
          err_d   = ~ccff_tail;
          state_d = FINISH;
        end else if (chk_vld_q && ccff_tail) begin
          err_d   = 1'b1;
          state_d = FINISH;
        end else if (cnt_q != SIZE) begin
          sen_d = 1'b1;
          cnt_d = cnt_inc;
        end
      end
      FINISH: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_q   <= IDLE;
      buf_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      head_q    <= 1'b0;
      sen_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      chk_vld_q <= 1'b0;
      chk_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      head_q    <= head_d;
      sen_q     <= sen_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      chk_vld_q <= chk_vld_d;
      chk_cnt_q <= chk_cnt_d;
    end
  end

  assign s.s_ready     = (state_q == FETCH);
  assign ccff_head     = head_q;
  assign ccff_shift_en = sen_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = err_q;
  assign bit_count     = cnt_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader with a behavioural
// configuration chain of selectable length.
module tb_ccff_chain_loader;

  localparam int SZ = 2655;
  localparam int WW = 32;
  localparam int CW = 12;
  localparam int NW = (SZ + WW - 1) / WW;

  logic          clk;
  logic          prog_reset;
  logic          start;
  logic          mode;
  logic          ccff_head;
  logic          ccff_shift_en;
  logic          ccff_tail;
  logic          busy;
  logic          done;
  logic          error;
  logic [CW-1:0] bit_count;

  ccff_chain_loader_if #(.WORD_W(WW)) ifc ();

  ccff_chain_loader #(
    .BITSTREAM_SIZE(SZ),
    .WORD_W(WW),
    .CNT_W(CW)
  ) dut (
    .prog_clk(clk),
    .prog_reset(prog_reset),
    .start(start),
    .mode(mode),
    .s(ifc.slave),
    .ccff_head(ccff_head),
    .ccff_shift_en(ccff_shift_en),
    .ccff_tail(ccff_tail),
    .busy(busy),
    .done(done),
    .error(error),
    .bit_count(bit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]   words [0:NW-1];
  logic [SZ-1:0] chain;
  int            chain_len;
  bit            stuck0;
  bit            src_on;
  bit            stall_on;
  int            widx;
  int            n_shift;
  int            late;
  int            stall_sh;
  int            stl;
  int            stl_w;
  int            n_chk;
  int            n_fail;

  assign ccff_tail = stuck0 ? 1'b0 : chain[chain_len-1];

  always @(posedge clk) begin
    if (prog_reset) chain <= '0;
    else if (ccff_shift_en)
      chain <= {chain[SZ-2:0], ccff_head};
  end

  always @(posedge clk) begin
    if (prog_reset) begin
      widx    <= 0;
      n_shift <= 0;
      late    <= 0;
    end else begin
      if (ifc.s_valid && ifc.s_ready) widx <= widx + 1;
      if (ccff_shift_en) n_shift <= n_shift + 1;
      if (ifc.s_ready && widx >= NW) late <= late + 1;
    end
  end

  // Word source; optionally starves FETCH before every 7th word.
  initial begin
    ifc.s_valid = 1'b0;
    ifc.s_data  = '0;
    stl      = 0;
    stl_w    = -1;
    stall_sh = 0;
    forever begin
      @(negedge clk);
      if (prog_reset) begin
        stl      = 0;
        stl_w    = -1;
        stall_sh = 0;
      end
      ifc.s_data = (widx < NW) ? words[widx] : 32'hDEAD_BEEF;
      if (src_on && stall_on && (widx % 7 == 6)
          && (stl_w != widx)) begin
        ifc.s_valid = 1'b0;
        if (ifc.s_ready) begin
          stl++;
          if (stl > 1 && ccff_shift_en) stall_sh++;
          if (stl == 6) begin
            stl         = 0;
            stl_w       = widx;
            ifc.s_valid = 1'b1;
          end
        end
      end else begin
        ifc.s_valid = src_on;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_img(input string tag);
    int m;
    logic [31:0] w;
    m = 0;
    for (int k = 0; k < SZ; k++) begin
      w = words[k / WW];
      if (chain[SZ-1-k] !== w[WW-1-(k % WW)]) m++;
    end
    chk(tag, m, 0);
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_head"}, ccff_head, 0);
    chk({tag, "_sen"}, ccff_shift_en, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, error, 0);
    chk({tag, "_cnt"}, bit_count, 0);
    chk({tag, "_rdy"}, ifc.s_ready, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    prog_reset = 1'b1;
    @(negedge clk);
    prog_reset = 1'b0;
  endtask

  task automatic pulse_start(input logic m);
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
    mode  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    while (!done && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk(tag, done, 1);
  endtask

  task automatic wait_cnt(input int v);
    int t;
    t = 0;
    while (bit_count != CW'(v) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("wait_cnt", bit_count, v);
  endtask

  initial begin
    int n0;
    int t;
    n_chk      = 0;
    n_fail     = 0;
    prog_reset = 1'b1;
    start      = 1'b0;
    mode       = 1'b0;
    src_on     = 1'b0;
    stall_on   = 1'b0;
    chain_len  = SZ;
    stuck0     = 1'b0;
    for (int i = 0; i < NW; i++)
      words[i] = 32'hC3A5_0F69 ^ (32'(i) * 32'h9E37_79B9);
    repeat (3) @(negedge clk);
    chk_idle_outs("rst");
    prog_reset = 1'b0;

    // LOAD, valid held high, start pulses in SHIFT and FINISH
    src_on = 1'b1;
    pulse_start(1'b0);
    wait_cnt(100);
    start = 1'b1;
    mode  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mode  = 1'b0;
    chk("s6_busy", busy, 1);
    t = 0;
    while (!(busy && !done && bit_count == CW'(SZ))
           && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("fin_seen", bit_count, SZ);
    start = 1'b1;
    mode  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("fin_done", done, 1);
    repeat (3) @(negedge clk);
    chk("fin_ign_busy", busy, 0);
    chk("s1_err", error, 0);
    chk("s1_cnt", bit_count, SZ);
    chk("s1_shifts", n_shift, SZ);
    chk("s1_words", widx, NW);
    chk("s1_late_rdy", late, 0);
    chk_img("s1_img");

    // LOAD with FETCH starvation before every 7th word
    do_reset();
    stall_on = 1'b1;
    pulse_start(1'b0);
    wait_done("s2_done");
    stall_on = 1'b0;
    chk("s2_cnt", bit_count, SZ);
    chk("s2_shifts", n_shift, SZ);
    chk("s2_stall_sen", stall_sh, 0);
    chk("s2_late_rdy", late, 0);
    chk_img("s2_img");

    // TEST, correct chain length
    do_reset();
    pulse_start(1'b1);
    wait_done("s3_done");
    chk("s3_err", error, 0);
    chk("s3_shifts", n_shift, SZ);
    chk("s3_cnt", bit_count, SZ);
    chk("s3_tail", ccff_tail, 1);
    chk("s3_no_words", widx, 0);

    // TEST, chain one bit short
    do_reset();
    chain_len = SZ - 1;
    pulse_start(1'b1);
    t = 0;
    while (!error && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("s4a_err", error, 1);
    chk("s4a_done_lag", done, 0);
    @(negedge clk);
    chk("s4a_done", done, 1);
    chk("s4a_busy", busy, 0);

    // TEST, tail stuck at 0
    do_reset();
    chain_len = SZ;
    stuck0    = 1'b1;
    pulse_start(1'b1);
    wait_done("s4b_done");
    chk("s4b_err", error, 1);
    chk("s4b_cnt", bit_count, SZ);
    chk("s4b_shifts", n_shift, SZ);
    stuck0 = 1'b0;

    // start after done clears done/error in the same edge
    n0 = n_shift;
    pulse_start(1'b0);
    chk("clr_done", done, 0);
    chk("clr_err", error, 0);
    chk("clr_busy", busy, 1);
    chk("clr_cnt", bit_count, 0);
    wait_done("s7_done");
    chk("s7_shifts", n_shift - n0, SZ);
    chk_img("s7_img");

    // reset in the middle of a LOAD
    do_reset();
    pulse_start(1'b0);
    wait_cnt(1000);
    prog_reset = 1'b1;
    @(negedge clk);
    chk_idle_outs("mid_rst");
    prog_reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_sen", ccff_shift_en, 0);
    pulse_start(1'b0);
    wait_done("s5_done");
    chk("s5_shifts", n_shift, SZ);
    chk("s5_words", widx, NW);
    chk_img("s5_img");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
